// File: rtl/memory_burst_ctrl_if.sv
// Bus bundle between the tile sequencer, the burst controller and the memory port.
// The controller connects through master; the sequencer/memory side through slave.
interface memory_burst_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 4
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_w_en_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [LEN_WIDTH-1:0]  cmd_len_i;
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  done_o;
  logic                  busy_o;
  logic                  mem_req_o;
  logic                  mem_w_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_w_data_o;
  logic [DATA_WIDTH-1:0] mem_r_data_i;
  logic                  mem_ack_i;

  modport master (
    input  cmd_valid_i, cmd_w_en_i, cmd_addr_i, cmd_len_i,
    input  wr_valid_i, wr_data_i, rd_ready_i, mem_r_data_i, mem_ack_i,
    output cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o, done_o, busy_o,
    output mem_req_o, mem_w_en_o, mem_addr_o, mem_w_data_o
  );

  modport slave (
    output cmd_valid_i, cmd_w_en_i, cmd_addr_i, cmd_len_i,
    output wr_valid_i, wr_data_i, rd_ready_i, mem_r_data_i, mem_ack_i,
    input  cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o, done_o, busy_o,
    input  mem_req_o, mem_w_en_o, mem_addr_o, mem_w_data_o
  );
endinterface

// File: rtl/memory_burst_ctrl.sv
// Multi-beat memory-bus master: queues burst commands and runs each one as a
// sequence of req/ack beats with write-data streaming and read-data backpressure.
module memory_burst_ctrl #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH   = 4,
  parameter int unsigned ADDR_STRIDE = 1,
  parameter int unsigned CMD_DEPTH   = 4
) (
  input logic               clk,
  input logic               reset,
  memory_burst_ctrl_if.master bus
);

  localparam int unsigned PtrW = $clog2(CMD_DEPTH);
  localparam int unsigned EntW = 1 + ADDR_WIDTH + LEN_WIDTH;
  localparam logic [PtrW:0]           PtrOne = (PtrW + 1)'(1);
  localparam logic [LEN_WIDTH-1:0]    CntOne = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]   Stride = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [1:0] {StIdle, StWrWait, StReq, StRdHold} state_e;

  // Command FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [EntW-1:0] fifo_q [CMD_DEPTH];
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic            fifo_full, fifo_empty, push, pop;
  logic [EntW-1:0] head;
  logic            head_w_en;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [LEN_WIDTH-1:0]  head_len;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  w_en_q, w_en_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  ack, last_beat;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push       = bus.cmd_valid_i & ~fifo_full;
  assign pop        = (state_q == StIdle) & ~fifo_empty;

  assign head      = fifo_q[rd_ptr_q[PtrW-1:0]];
  assign head_w_en = head[EntW-1];
  assign head_addr = head[ADDR_WIDTH+LEN_WIDTH-1:LEN_WIDTH];
  assign head_len  = head[LEN_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q[PtrW-1:0]] <= {bus.cmd_w_en_i, bus.cmd_addr_i, bus.cmd_len_i};
        wr_ptr_q                   <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  // Only an ack that meets a raised request counts; stray acks fall through.
  assign ack       = req_q & bus.mem_ack_i;
  assign last_beat = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    w_en_d  = w_en_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    req_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          addr_d  = head_addr;
          cnt_d   = head_len;
          w_en_d  = head_w_en;
          state_d = head_w_en ? StWrWait : StReq;
        end
      end
      StWrWait: begin
        if (bus.wr_valid_i) begin
          wdata_d = bus.wr_data_i;
          state_d = StReq;
        end
      end
      StReq: begin
        // Request rises one cycle after entering REQ and drops on the accepting edge.
        req_d = ~ack;
        if (ack) begin
          if (!w_en_q) begin
            rdata_d = bus.mem_r_data_i;
            state_d = StRdHold;
          end else if (last_beat) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + Stride;
            cnt_d   = cnt_q - CntOne;
            state_d = StWrWait;
          end
        end
      end
      StRdHold: begin
        if (bus.rd_ready_i) begin
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + Stride;
            cnt_d   = cnt_q - CntOne;
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      w_en_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      w_en_q  <= w_en_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready_o  = ~fifo_full;
  assign bus.wr_ready_o   = (state_q == StWrWait);
  assign bus.rd_valid_o   = (state_q == StRdHold);
  assign bus.rd_data_o    = rdata_q;
  assign bus.done_o       = done_q;
  assign bus.busy_o       = ~fifo_empty | (state_q != StIdle);
  assign bus.mem_req_o    = req_q;
  assign bus.mem_w_en_o   = w_en_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_w_data_o = wdata_q;

endmodule

// File: tb/tb_memory_burst_ctrl.sv
// Randomized bench for memory_burst_ctrl: a command/beat-level model predicts every
// memory transaction, read beat and done pulse, plus directed literal scenarios.
module tb_memory_burst_ctrl;
  localparam int unsigned DW = 256;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 4;
  localparam int unsigned STRIDE = 1;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  memory_burst_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  memory_burst_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ADDR_STRIDE(STRIDE), .CMD_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Environment knobs
  bit stall = 1'b0;
  bit stray_ack = 1'b0;
  int max_lat = 3;
  bit rd_hold = 1'b0;
  bit rd_force = 1'b0;
  int wr_mode = 0;  // 0 random, 1 held low, 2 always offered

  // Memory: acks each request after a random latency, one cycle per transaction.
  bit ack_gen = 1'b0;
  int lat = -1;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      ack_gen = 1'b0;
      lat = -1;
    end else if (ack_gen) begin
      ack_gen = 1'b0;
    end else if (bus.mem_req_o && !stall) begin
      if (lat < 0) lat = $urandom_range(max_lat, 0);
      if (lat == 0) begin
        ack_gen = 1'b1;
        for (int i = 0; i < DW / 32; i++) bus.mem_r_data_i[i*32 +: 32] = $urandom;
        lat = -1;
      end else begin
        lat--;
      end
    end
    bus.mem_ack_i = ack_gen | stray_ack;
  end

  always @(posedge clk) begin
    #1;
    bus.rd_ready_i = rd_hold ? 1'b0 : (rd_force ? 1'b1 : ($urandom_range(9, 0) < 7));
  end

  always @(posedge clk) begin
    #1;
    case (wr_mode)
      1: bus.wr_valid_i = 1'b0;
      2: bus.wr_valid_i = 1'b1;
      default: bus.wr_valid_i = $urandom_range(1, 0) == 1;
    endcase
    for (int i = 0; i < DW / 32; i++) bus.wr_data_i[i*32 +: 32] = $urandom;
  end

  // Behavioural model: commands in push order, beats expanded by address arithmetic.
  typedef struct {
    bit          w;
    logic [AW-1:0] addr;
    int          len;
  } cmd_t;

  cmd_t cmdq[$];
  cmd_t cur;
  bit active = 1'b0;
  int beat = 0;
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rdq[$];
  logic [AW-1:0] alog[$];
  bit exp_done = 1'b0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    bit fin;
    fin = 1'b0;
    if (chk_en) begin
      chk("done", bus.done_o, exp_done);
      chk("busy", bus.busy_o, (cmdq.size() > 0) || active);
      chk("req_while_hold", bus.mem_req_o && (bus.rd_valid_o || bus.wr_ready_o), 1'b0);
      if (bus.rd_valid_o) begin
        if (rdq.size() == 0) chk("rd_valid_unexpected", 1'b1, 1'b0);
        else chk("rd_data", bus.rd_data_o, rdq[0]);
      end
      if (bus.done_o) done_cnt++;
    end
    if (reset) begin
      cmdq.delete();
      wq.delete();
      rdq.delete();
      active = 1'b0;
    end else begin
      if (bus.cmd_valid_i && bus.cmd_ready_o)
        cmdq.push_back('{w: bus.cmd_w_en_i, addr: bus.cmd_addr_i, len: int'(bus.cmd_len_i)});
      if (bus.wr_valid_i && bus.wr_ready_o) wq.push_back(bus.wr_data_i);
      if (bus.mem_req_o && bus.mem_ack_i) begin
        if (!active) begin
          if (cmdq.size() == 0) chk("cmd_underflow", 1'b1, 1'b0);
          else begin
            cur = cmdq.pop_front();
            active = 1'b1;
            beat = 0;
          end
        end
        if (active) begin
          alog.push_back(bus.mem_addr_o);
          chk("mem_w_en", bus.mem_w_en_o, cur.w);
          chk("mem_addr", bus.mem_addr_o, AW'(cur.addr + beat * STRIDE));
          if (cur.w) begin
            if (wq.size() == 0) chk("wr_beat_missing", 1'b1, 1'b0);
            else chk("mem_w_data", bus.mem_w_data_o, wq.pop_front());
            beat++;
            if (beat > cur.len) begin
              fin = 1'b1;
              active = 1'b0;
            end
          end else begin
            rdq.push_back(bus.mem_r_data_i);
          end
        end
      end
      if (bus.rd_valid_o && bus.rd_ready_i && active) begin
        if (rdq.size() > 0) void'(rdq.pop_front());
        beat++;
        if (beat > cur.len) begin
          fin = 1'b1;
          active = 1'b0;
        end
      end
    end
    exp_done = fin;
  end

  task automatic push_cmd(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    @(posedge clk);
    #1;
    bus.cmd_w_en_i = w;
    bus.cmd_addr_i = a;
    bus.cmd_len_i = l;
    bus.cmd_valid_i = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("cmd_push_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy_o || cmdq.size() > 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("idle_timeout", 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_sig(input int which, input string name);
    int n = 0;
    @(negedge clk);
    while (!(which == 0 ? bus.mem_req_o : bus.rd_valid_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk(name, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_w_en_i = 1'b0;
    bus.cmd_addr_i = '0;
    bus.cmd_len_i = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_req", bus.mem_req_o, 1'b0);
    chk("rst_rd_valid", bus.rd_valid_o, 1'b0);
    chk("rst_wr_ready", bus.wr_ready_o, 1'b0);
    chk("rst_addr", bus.mem_addr_o, 16'h0000);
    chk_en = 1'b1;

    // Read burst at 0x0010, four beats, prompt ack, consumer always ready.
    max_lat = 0;
    rd_force = 1'b1;
    alog.delete();
    d0 = done_cnt;
    @(posedge clk);
    #1;
    bus.cmd_w_en_i = 1'b0;
    bus.cmd_addr_i = 16'h0010;
    bus.cmd_len_i = 4'd3;
    bus.cmd_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("lat_t0_req", bus.mem_req_o, 1'b0);
    @(negedge clk);
    chk("lat_t1_req", bus.mem_req_o, 1'b0);
    @(negedge clk);
    chk("lat_t2_req", bus.mem_req_o, 1'b1);
    wait_idle();
    chk("rd4_beats", alog.size(), 4);
    if (alog.size() == 4) begin
      chk("rd4_addr0", alog[0], 16'h0010);
      chk("rd4_addr1", alog[1], 16'h0011);
      chk("rd4_addr2", alog[2], 16'h0012);
      chk("rd4_addr3", alog[3], 16'h0013);
    end
    chk("rd4_done", done_cnt - d0, 1);

    // Write burst, two beats, write data held back for three cycles.
    wr_mode = 1;
    alog.delete();
    d0 = done_cnt;
    push_cmd(1'b1, 16'h0200, 4'd1);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("wrwait_ready", bus.wr_ready_o, 1'b1);
      chk("wrwait_req", bus.mem_req_o, 1'b0);
    end
    wr_mode = 2;
    wait_idle();
    chk("wr2_beats", alog.size(), 2);
    if (alog.size() == 2) begin
      chk("wr2_addr0", alog[0], 16'h0200);
      chk("wr2_addr1", alog[1], 16'h0201);
    end
    chk("wr2_done", done_cnt - d0, 1);
    chk("wr2_data_drained", wq.size(), 0);

    // Address wrap at the top of the map.
    alog.delete();
    push_cmd(1'b0, 16'hFFFF, 4'd1);
    wait_idle();
    chk("wrap_beats", alog.size(), 2);
    if (alog.size() == 2) begin
      chk("wrap_addr0", alog[0], 16'hFFFF);
      chk("wrap_addr1", alog[1], 16'h0000);
    end

    // Read backpressure: consumer stalls five cycles.
    rd_hold = 1'b1;
    d0 = done_cnt;
    push_cmd(1'b0, 16'h0040, 4'd1);
    wait_sig(1, "rd_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      chk("bp_rd_valid", bus.rd_valid_o, 1'b1);
      chk("bp_no_req", bus.mem_req_o, 1'b0);
    end
    rd_hold = 1'b0;
    wait_idle();
    chk("bp_done", done_cnt - d0, 1);

    // FIFO fill while the engine is stalled on an ack.
    rd_force = 1'b0;
    wr_mode = 0;
    max_lat = 2;
    stall = 1'b1;
    d0 = done_cnt;
    alog.delete();
    push_cmd(1'b0, 16'h0100, 4'd0);
    wait_sig(0, "stall_req_timeout");
    push_cmd(1'b1, 16'h0110, 4'd1);
    push_cmd(1'b0, 16'h0120, 4'd2);
    push_cmd(1'b1, 16'h0130, 4'd0);
    @(negedge clk);
    chk("fifo_ready_at3", bus.cmd_ready_o, 1'b1);
    push_cmd(1'b0, 16'h0140, 4'd1);
    @(negedge clk);
    chk("fifo_full_at4", bus.cmd_ready_o, 1'b0);
    stall = 1'b0;
    wait_idle();
    chk("fifo_done5", done_cnt - d0, 5);
    chk("fifo_beats", alog.size(), 9);
    if (alog.size() == 9) begin
      chk("fifo_order_b0", alog[0], 16'h0100);
      chk("fifo_order_b1", alog[1], 16'h0110);
      chk("fifo_order_b3", alog[3], 16'h0120);
      chk("fifo_order_b6", alog[6], 16'h0130);
      chk("fifo_order_b8", alog[8], 16'h0141);
    end

    // Reset in the middle of a burst, with one command still queued.
    stall = 1'b1;
    d0 = done_cnt;
    push_cmd(1'b0, 16'h0300, 4'd3);
    wait_sig(0, "rst_req_timeout");
    push_cmd(1'b1, 16'h0400, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    stray_ack = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", bus.mem_req_o, 1'b0);
    chk("mid_rst_busy", bus.busy_o, 1'b0);
    chk("mid_rst_ready", bus.cmd_ready_o, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("stray_ack_req", bus.mem_req_o, 1'b0);
      chk("stray_ack_busy", bus.busy_o, 1'b0);
      chk("stray_ack_rd_valid", bus.rd_valid_o, 1'b0);
    end
    stray_ack = 1'b0;
    chk("mid_rst_no_done", done_cnt - d0, 0);

    // Randomized command mix.
    max_lat = 3;
    d0 = done_cnt;
    for (int k = 0; k < 40; k++) begin
      logic [AW-1:0] a;
      if ($urandom_range(3, 0) == 0) a = 16'hFFF0 + AW'($urandom_range(15, 0));
      else a = AW'($urandom);
      push_cmd($urandom_range(1, 0) == 1, a, LW'($urandom_range(15, 0)));
    end
    wait_idle();
    chk("rand_done_count", done_cnt - d0, 40);
    chk("rand_rd_drained", rdq.size(), 0);
    chk("rand_wr_drained", wq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
